sprite_fetch_arbiter: RTL and testbench
=======================================

// Module: sprite_fetch_arbiter
// PURPOSE
//  Shares one single-port sprite RAM between up to N_REQ render layers (raccoon, cars, grass, dotted line).
//  Each layer issues req/addr and receives the sprite word, tagged one-hot, after a fixed latency.
//  Sits between the VGA pixel pipeline and one ram instance, replacing one RAM per layer.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  ADDR_W       10  sprite RAM address width
//  DATA_W       9   sprite word width ({R[2:0],G[2:0],B[2:0]})
//  RAM_LATENCY  1   cycles from ram_addr/ram_rd registered to ram_data valid (1..3)
// PORTS
//  clk        in   1              pixel clock; all logic on posedge
//  rst_n      in   1              synchronous reset, active-low
//  req        in   N_REQ          per-requester read request, level
//  req_addr   in   N_REQ*ADDR_W   packed addresses; slice i = [i*ADDR_W +: ADDR_W]
//  gnt        out  N_REQ          one-hot combinational grant; transfer = req[i]&gnt[i] at posedge
//  ram_addr   out  ADDR_W         registered address to shared RAM
//  ram_rd     out  1              registered read strobe; high for exactly the cycle ram_addr is new
//  ram_data   in   DATA_W         RAM read data, valid RAM_LATENCY cycles after ram_rd
//  rsp_valid  out  N_REQ          one-hot registered response tag; single-cycle pulse
//  rsp_data   out  DATA_W         registered sprite word paired with rsp_valid
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ram_addr=0, ram_rd=0, rsp_valid=0, rsp_data=0, rr_ptr=0, tag pipe cleared.
//    gnt=0 during any cycle rst_n=0. Reset mid-flight drops all in-flight reads; no rsp_valid for them.
//  - gnt: at most one bit set; gnt[i] only if req[i]. No req -> gnt=0, ram_rd=0 next cycle.
//  - Round-robin: search req from index rr_ptr upward, wrapping N_REQ-1 -> 0; first set bit wins.
//    On transfer to i: rr_ptr <= (i==N_REQ-1) ? 0 : i+1. No transfer -> rr_ptr holds.
//  - Transfer at edge E: ram_addr <= req_addr[i], ram_rd <= 1, tag[0] <= onehot(i).
//    Tag shifts through 1+RAM_LATENCY stages; rsp_data <= ram_data and rsp_valid <= tag at edge E+1+RAM_LATENCY.
//    RAM_LATENCY=1 -> response visible 2 cycles after the accept edge.
//  - Throughput: one transfer per cycle total; a requester holding req high is re-granted only when its turn
//    comes, so with k active requesters each gets one grant every k cycles.
//  - Requester must hold req_addr stable while req high and not granted; after transfer it may keep req high
//    with a new address (back-to-back accepted if it wins again).
//  - req dropped before grant: request withdrawn, no transfer, rr_ptr unaffected.
//  - ram_addr holds last value when ram_rd=0; rsp_data holds last value when rsp_valid=0.
//  - Responses returned strictly in grant order; no backpressure on rsp (consumer must accept).
// CONFIGURATION
//  SPRITE_ARB_FIXED_PRIO_EN defined: fixed priority, req[0] highest, req[N_REQ-1] lowest; rr_ptr not
//    implemented; a continuously requesting low index starves higher indices (intended for raccoon on top).
//  Undefined (default): round-robin as above.
// TESTING
//  1 Single: rst_n low 2 cycles, then req=0001, addr0=10'h05A -> gnt=0001 same cycle, ram_rd=1/ram_addr=05A next
//    cycle, rsp_valid=0001 with rsp_data=RAM[05A] 2 cycles after accept (RAM_LATENCY=1).
//  2 All four req held high 8 cycles, distinct addrs -> grant order 0,1,2,3,0,1,2,3; rsp_valid order identical,
//    each rsp_data matching its address.
//  3 req=1010 with rr_ptr=2 -> gnt=1000 then 0010 next cycle; rr_ptr ends at 2.
//  4 Three reads in flight, rst_n=0 one cycle -> no rsp_valid afterwards until new request; all outputs 0.
//  5 req[2] asserted one cycle while req[0] wins, then dropped -> no grant/response for 2; rr_ptr=1.
//  6 With SPRITE_ARB_FIXED_PRIO_EN and RAM_LATENCY=3: req=0101 held -> gnt=0001 every cycle, req[2] never
//    granted; rsp latency = 4 cycles.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// Shares one single-port sprite RAM between N_REQ render layers, returning one-hot tagged read data.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (req_i[0] highest); default build is round-robin.
module sprite_fetch_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 9,
  parameter int RAM_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]       ram_addr_o,
  output logic                    ram_rd_o,
  input  logic [DATA_W-1:0]       ram_data_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]  win_idx_s;
  logic              win_s;
  logic              hit_s;
  logic [IDX_W-1:0]  cand_s;
  logic [N_REQ-1:0]  gnt_s;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_rd_q, ram_rd_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  // Stage k holds the one-hot tag of the read accepted k+1 edges ago.
  logic [RAM_LATENCY:0][N_REQ-1:0] tag_q, tag_d;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    s = (s >= N_REQ) ? (s - N_REQ) : s;
    return IDX_W'(s);
  endfunction
`endif

  // Arbitration: pick the first requesting index in search order.
  always_comb begin
    win_idx_s = '0;
    win_s     = 1'b0;
    hit_s     = 1'b0;
    cand_s    = '0;
    gnt_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      cand_s = IDX_W'(k);
`else
      cand_s = rr_index(rr_ptr_q, k);
`endif
      hit_s     = req_i[cand_s] & ~win_s;
      win_idx_s = hit_s ? cand_s : win_idx_s;
      win_s     = win_s | hit_s;
    end
    gnt_s[win_idx_s] = win_s & rst_ni;
  end

  assign gnt_o = gnt_s;

  // Next-state for the RAM port, tag pipe and response registers.
  always_comb begin
    ram_rd_d    = gnt_s[win_idx_s];
    ram_addr_d  = ram_rd_d ? req_addr_i[win_idx_s*ADDR_W +: ADDR_W] : ram_addr_q;
    tag_d       = {tag_q[RAM_LATENCY-1:0], gnt_s};
    rsp_valid_d = tag_q[RAM_LATENCY];
    rsp_data_d  = (|tag_q[RAM_LATENCY]) ? ram_data_i : rsp_data_q;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    if (ram_rd_d) begin
      rr_ptr_d = (win_idx_s == IDX_W'(N_REQ - 1)) ? '0 : (win_idx_s + IDX_W'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
`endif
  end

  // State registers with synchronous active-low reset; reset drops in-flight tags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_rd_q    <= ram_rd_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_rd_o    = ram_rd_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Self-checking bench for sprite_fetch_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_sprite_fetch_arbiter;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int DW  = 9;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [AW-1:0] addr [N];
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [DW-1:0] ram_data;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] ram_pipe [LAT];

  typedef struct { int due; logic [N-1:0] oh; logic [DW-1:0] d; } rsp_t;
  rsp_t          q[$];
  rsp_t          r;
  int            ptr, cyc, last_win;
  bit            mvalid;
  logic          exp_rd;
  logic [AW-1:0] exp_addr;
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rdata;
  int            tests, fails;

  always #5 clk = ~clk;

  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};
  assign ram_data = ram_pipe[LAT-1];

  // Sprite RAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 9'h1A5;
  endfunction

  always @(posedge clk) begin
    ram_pipe[0] <= ram_word(ram_addr);
    for (int j = 1; j < LAT; j++) ram_pipe[j] <= ram_pipe[j-1];
  end

  sprite_fetch_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_addr_i(req_addr), .gnt_o(gnt),
    .ram_addr_o(ram_addr), .ram_rd_o(ram_rd), .ram_data_i(ram_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data));

  function automatic int winner(input logic [N-1:0] rq, input int p);
    for (int k = 0; k < N; k++) begin
      if (rq[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: compare every output to the model at negedge, then advance the model at posedge.
  task automatic tick();
    int w;
    @(negedge clk);
    if (mvalid) begin
      check("gnt", 32'(gnt), 32'(rst_n ? onehot(winner(req, ptr)) : 4'b0000));
      check("ram_rd", 32'(ram_rd), 32'(exp_rd));
      check("ram_addr", 32'(ram_addr), 32'(exp_addr));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("rsp_data", 32'(rsp_data), 32'(exp_rdata));
    end
    @(posedge clk);
    if (!rst_n) begin
      mvalid = 1'b1; ptr = 0; exp_rd = 1'b0; exp_addr = '0; exp_rv = '0; exp_rdata = '0;
      q.delete(); last_win = -1;
    end else begin
      exp_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        exp_rv = r.oh;
        exp_rdata = r.d;
      end
      w = winner(req, ptr);
      last_win = w;
      exp_rd = (w >= 0);
      if (w >= 0) begin
        exp_addr = addr[w];
        r.due = cyc + 1 + LAT; r.oh = onehot(w); r.d = ram_word(addr[w]);
        q.push_back(r);
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        ptr = (w + 1) % N;
`endif
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; ptr = 0; mvalid = 1'b0; last_win = -1;
    exp_rd = 1'b0; exp_addr = '0; exp_rv = '0; exp_rdata = '0;
    rst_n = 1'b0; req = '0;
    for (int i = 0; i < N; i++) addr[i] = '0;
    tick(); tick();

    // Single read from layer 0
    rst_n = 1'b1; req = 4'b0001; addr[0] = 10'h05A;
    #1 check("t1_gnt", 32'(gnt), 32'h1);
    tick();
    check("t1_ram_rd", 32'(ram_rd), 32'h1);
    check("t1_ram_addr", 32'(ram_addr), 32'h05A);
    req = '0;
    tick(); tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", 32'(rsp_data), 32'h1FF);
    tick();

    // All four layers held high: rotation 0,1,2,3,0,1,2,3
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) addr[i] = 10'h100 + 10'(i);
    for (int c = 0; c < 8; c++) begin
      #1 check("t2_order", 32'(gnt), 32'(4'b0001 << (c % 4)));
      tick();
      addr[c % 4] = addr[c % 4] + 10'h010;
    end
    req = '0;
    repeat (4) tick();

    // req=1010 with pointer at 2
    do_reset();
    req = 4'b0010; addr[1] = 10'h0AA;
    tick();
    req = 4'b1010; addr[3] = 10'h3C3;
    #1 check("t3_first", 32'(gnt), 32'h8);
    tick();
    #1 check("t3_second", 32'(gnt), 32'h2);
    tick();
    req = 4'b1111;
    #1 check("t3_ptr2", 32'(gnt), 32'h4);
    req = '0;
    repeat (3) tick();

    // Reset with reads in flight
    do_reset();
    req = 4'b0111; addr[0] = 10'h001; addr[1] = 10'h002; addr[2] = 10'h003;
    repeat (3) tick();
    rst_n = 1'b0;
    #1 check("t4_gnt_rst", 32'(gnt), 32'h0);
    tick();
    rst_n = 1'b1; req = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_rsp_valid", 32'(rsp_valid), 32'h0);
      check("t4_rsp_data", 32'(rsp_data), 32'h0);
      check("t4_ram_rd", 32'(ram_rd), 32'h0);
      check("t4_ram_addr", 32'(ram_addr), 32'h0);
    end

    // Withdrawn request for layer 2
    do_reset();
    req = 4'b0101; addr[0] = 10'h011; addr[2] = 10'h022;
    #1 check("t5_gnt0", 32'(gnt), 32'h1);
    tick();
    req = '0;
    repeat (3) tick();
    check("t5_no_rsp2", 32'(rsp_valid), 32'h0);
    req = 4'b0011;
    #1 check("t5_ptr1", 32'(gnt), 32'h2);
    req = '0;
    tick();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_win == i) begin
          addr[i] = 10'($urandom);
          req[i] = ($urandom_range(0, 9) < 6);
        end else if ($urandom_range(0, 9) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    rst_n = 1'b1; req = '0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
